// File: rtl/yacht_score_card.sv
// Two-player Yacht scorecard: validates and records score commits, keeps
// the upper-section sums, the one-time upper bonus and the running totals,
// and serves a registered single-cell query port for the FSM and displays.
//
// state  | meaning
// IDLE   | ready for a commit; latches player/cat/score on acceptance
// CHECK  | reject out-of-range or already-used category
// WRITE  | record score, mark cell used, update total and upper sum
// BONUS  | grant the upper bonus once, pulse ack, refresh game_over
module yacht_score_card #(
    parameter int NUM_CAT      = 12,
    parameter int UPPER_CATS   = 6,
    parameter int BONUS_THRESH = 63,
    parameter int BONUS_PTS    = 35
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       commit_valid,
    output logic       commit_ready,
    input  logic       commit_player,
    input  logic [3:0] commit_cat,
    input  logic [7:0] commit_score,
    output logic       commit_ack,
    output logic       commit_err,
    input  logic       query_player,
    input  logic [3:0] query_cat,
    output logic       query_used,
    output logic [7:0] query_score,
    output logic [8:0] p1_total,
    output logic [8:0] p2_total,
    output logic       p1_bonus,
    output logic       p2_bonus,
    output logic       game_over
);

    localparam logic [3:0] NUM_C    = 4'(NUM_CAT);
    localparam logic [3:0] UPPER_C  = 4'(UPPER_CATS);
    localparam logic [8:0] THRESH_C = 9'(BONUS_THRESH);
    localparam logic [8:0] PTS_C    = 9'(BONUS_PTS);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_BONUS} state_t;

    state_t             state_q;
    logic               player_q;
    logic [3:0]         cat_q;
    logic [7:0]         score_q;
    logic [7:0]         card_q  [2][NUM_CAT];
    logic [NUM_CAT-1:0] used_q  [2];
    logic [8:0]         upper_q [2];
    logic [8:0]         total_q [2];
    logic [1:0]         bonus_q;
    logic               ack_q;
    logic               err_q;
    logic               over_q;
    logic               query_used_q;
    logic [7:0]         query_score_q;

    logic               reject_d;
    logic [8:0]         total_wr_d;
    logic [8:0]         upper_wr_d;
    logic               grant_d;
    logic [8:0]         total_bonus_d;

    function automatic logic [8:0] sat_add(input logic [8:0] a, input logic [8:0] b);
        logic [9:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[9] ? 9'h1FF : s[8:0];
    endfunction

    // Next-state arithmetic for the latched commit, shared by CHECK/WRITE/BONUS.
    always_comb begin
        reject_d      = 1'b1;
        if (cat_q < NUM_C) begin
            reject_d = used_q[player_q][cat_q];
        end
        total_wr_d    = sat_add(total_q[player_q], {1'b0, score_q});
        upper_wr_d    = sat_add(upper_q[player_q], {1'b0, score_q});
        grant_d       = (upper_q[player_q] >= THRESH_C) && !bonus_q[player_q];
        total_bonus_d = sat_add(total_q[player_q], PTS_C);
    end

    // Commit FSM and card storage; new_game clears everything like reset.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state_q  <= S_IDLE;
            player_q <= 1'b0;
            cat_q    <= '0;
            score_q  <= '0;
            bonus_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            over_q   <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                used_q[p]  <= '0;
                upper_q[p] <= '0;
                total_q[p] <= '0;
                for (int c = 0; c < NUM_CAT; c++) begin
                    card_q[p][c] <= '0;
                end
            end
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (commit_valid) begin
                        player_q <= commit_player;
                        cat_q    <= commit_cat;
                        score_q  <= commit_score;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (reject_d) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    card_q[player_q][cat_q] <= score_q;
                    used_q[player_q][cat_q] <= 1'b1;
                    total_q[player_q]       <= total_wr_d;
                    if (cat_q < UPPER_C) begin
                        upper_q[player_q] <= upper_wr_d;
                    end
                    state_q <= S_BONUS;
                end
                S_BONUS: begin
                    if (grant_d) begin
                        bonus_q[player_q] <= 1'b1;
                        total_q[player_q] <= total_bonus_d;
                    end
                    ack_q   <= 1'b1;
                    over_q  <= (&used_q[0]) && (&used_q[1]);
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Registered cell read; a same-cycle write is seen on the following read.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            query_used_q  <= 1'b0;
            query_score_q <= '0;
        end else if (query_cat < NUM_C) begin
            query_used_q  <= used_q[query_player][query_cat];
            query_score_q <= card_q[query_player][query_cat];
        end else begin
            query_used_q  <= 1'b0;
            query_score_q <= '0;
        end
    end

    assign commit_ready = (state_q == S_IDLE);
    assign commit_ack   = ack_q;
    assign commit_err   = err_q;
    assign query_used   = query_used_q;
    assign query_score  = query_score_q;
    assign p1_total     = total_q[0];
    assign p2_total     = total_q[1];
    assign p1_bonus     = bonus_q[0];
    assign p2_bonus     = bonus_q[1];
    assign game_over    = over_q;

endmodule

// File: tb/tb_yacht_score_card.sv
// Bench for yacht_score_card: a table of commits with hand-derived ack/err
// outcomes, a small card model feeding a scoreboard queue, and hand-written
// sequences for new_game/reset aborts.
module tb_yacht_score_card;

    logic       clk = 1'b0;
    logic       reset, new_game, commit_valid, commit_ready, commit_player;
    logic [3:0] commit_cat, query_cat;
    logic [7:0] commit_score, query_score;
    logic       commit_ack, commit_err, query_player, query_used;
    logic [8:0] p1_total, p2_total;
    logic       p1_bonus, p2_bonus, game_over;

    yacht_score_card dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_player(commit_player), .commit_cat(commit_cat),
        .commit_score(commit_score), .commit_ack(commit_ack),
        .commit_err(commit_err), .query_player(query_player),
        .query_cat(query_cat), .query_used(query_used),
        .query_score(query_score), .p1_total(p1_total), .p2_total(p2_total),
        .p1_bonus(p1_bonus), .p2_bonus(p2_bonus), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       p;
        logic [3:0] c;
        logic [7:0] s;
        logic       exp_ack;
    } vec_t;

    typedef struct {
        logic       ack;
        int         lat;
        int         t1, t2;
        logic       b1, b2, go;
        logic [7:0] s;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    int m_total[2];
    int m_upper[2];
    bit m_bonus[2];
    bit m_used[2][16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 511) ? 511 : v;
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) begin
            m_total[p] = 0;
            m_upper[p] = 0;
            m_bonus[p] = 0;
            for (int c = 0; c < 16; c++) m_used[p][c] = 0;
        end
    endfunction

    function automatic bit model_all_used();
        bit all = 1;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 12; c++)
                if (!m_used[p][c]) all = 0;
        return all;
    endfunction

    function automatic void add_vec(input logic p, input logic [3:0] c, input logic [7:0] s, input logic a);
        vec_t v;
        v.p = p; v.c = c; v.s = s; v.exp_ack = a;
        vecs.push_back(v);
    endfunction

    // Entered #1 after a rising edge; returns #1 after the ack/err edge.
    task automatic commit(input logic p, input logic [3:0] c, input logic [7:0] s, input logic exp_ack);
        exp_t e;
        int   n;
        bit   got;
        n = 0;
        while (!commit_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", commit_ready, 1);
        commit_valid = 1; commit_player = p; commit_cat = c; commit_score = s;
        query_player = p; query_cat = c;
        @(posedge clk); #1;
        commit_valid = 0;
        e.ack = exp_ack;
        e.lat = exp_ack ? 3 : 1;
        e.s   = s;
        if (exp_ack) begin
            m_used[p][c] = 1;
            m_total[p] = sat(m_total[p] + int'(s));
            if (c < 6) m_upper[p] = sat(m_upper[p] + int'(s));
            if (m_upper[p] >= 63 && !m_bonus[p]) begin
                m_bonus[p] = 1;
                m_total[p] = sat(m_total[p] + 35);
            end
        end
        e.t1 = m_total[0]; e.t2 = m_total[1];
        e.b1 = m_bonus[0]; e.b2 = m_bonus[1];
        e.go = model_all_used();
        sb.push_back(e);
        got = 0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(posedge clk); #1;
            if (exp_ack && k == 2) check("query_same_cycle_old", query_used, 0);
            if (commit_ack || commit_err) begin
                got = 1;
                e = sb.pop_front();
                check("ack", commit_ack, e.ack);
                check("err", commit_err, !e.ack);
                check("latency", k, e.lat);
                check("ready_after", commit_ready, 1);
                check("p1_total", p1_total, e.t1);
                check("p2_total", p2_total, e.t2);
                check("p1_bonus", p1_bonus, e.b1);
                check("p2_bonus", p2_bonus, e.b2);
                check("game_over", game_over, e.go);
                if (e.ack) begin
                    check("query_used_new", query_used, 1);
                    check("query_score_new", query_score, e.s);
                end
            end
        end
        if (!got) begin
            check("pulse_timeout", 0, 1);
            void'(sb.pop_front());
        end
    endtask

    task automatic do_query(input logic p, input logic [3:0] c, input logic u, input logic [7:0] s);
        query_player = p; query_cat = c;
        @(posedge clk); #1;
        check("query_used", query_used, u);
        check("query_score", query_score, s);
    endtask

    task automatic no_pulse(input string name, input int cycles);
        int seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (commit_ack || commit_err) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        reset = 1; new_game = 0; commit_valid = 0; commit_player = 0;
        commit_cat = 0; commit_score = 0; query_player = 0; query_cat = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", commit_ready, 1);
        check("rst_p1_total", p1_total, 0);
        check("rst_p2_total", p2_total, 0);
        check("rst_ack_err", {commit_ack, commit_err}, 0);
        check("rst_flags", {p1_bonus, p2_bonus, game_over}, 0);
        check("rst_query", {query_used, query_score}, 0);
        reset = 0;

        add_vec(0, 11, 50, 1);
        add_vec(0, 11, 40, 0);
        add_vec(1, 0, 3, 1);  add_vec(1, 1, 8, 1);  add_vec(1, 2, 12, 1);
        add_vec(1, 3, 16, 1); add_vec(1, 4, 20, 1); add_vec(1, 5, 4, 1);
        add_vec(0, 12, 5, 0);
        add_vec(1, 15, 5, 0);
        add_vec(0, 0, 5, 1);  add_vec(0, 1, 10, 1); add_vec(0, 2, 15, 1);
        add_vec(0, 3, 20, 1); add_vec(0, 4, 25, 1); add_vec(0, 5, 30, 1);
        add_vec(0, 6, 250, 1); add_vec(0, 7, 250, 1); add_vec(0, 8, 0, 1);
        add_vec(0, 9, 7, 1);  add_vec(0, 10, 9, 1);
        add_vec(1, 6, 25, 1); add_vec(1, 7, 30, 1); add_vec(1, 8, 40, 1);
        add_vec(1, 9, 50, 1); add_vec(1, 10, 0, 1); add_vec(1, 11, 12, 1);
        add_vec(0, 0, 99, 0);

        foreach (vecs[i]) begin
            commit(vecs[i].p, vecs[i].c, vecs[i].s, vecs[i].exp_ack);
            if (i == 0) begin
                check("first_p1_total", p1_total, 50);
                check("first_p2_total", p2_total, 0);
            end
            if (i == 7) begin
                check("upper_p2_total", p2_total, 98);
                check("upper_p2_bonus", p2_bonus, 1);
            end
        end

        check("full_p1_total_sat", p1_total, 511);
        check("full_p2_total", p2_total, 255);
        check("full_p1_bonus", p1_bonus, 1);
        @(posedge clk); #1;
        check("game_over_hold", game_over, 1);
        do_query(0, 13, 0, 0);
        do_query(1, 9, 1, 50);
        do_query(0, 8, 1, 0);

        new_game = 1;
        @(posedge clk); #1;
        new_game = 0;
        model_reset();
        check("ng_totals", {p1_total, p2_total}, 0);
        check("ng_flags", {p1_bonus, p2_bonus, game_over}, 0);
        check("ng_ready", commit_ready, 1);
        do_query(1, 9, 0, 0);

        // new_game arriving while the commit sits in WRITE aborts it silently.
        query_player = 0; query_cat = 3;
        commit_valid = 1; commit_player = 0; commit_cat = 3; commit_score = 9;
        @(posedge clk); #1;
        commit_valid = 0;
        @(posedge clk); #1;
        new_game = 1;
        @(posedge clk); #1;
        new_game = 0;
        no_pulse("abort_no_pulse", 6);
        check("abort_p1_total", p1_total, 0);
        do_query(0, 3, 0, 0);
        commit(0, 3, 9, 1);

        // reset with commit_valid high must not record the commit.
        commit_valid = 1; commit_player = 1; commit_cat = 2; commit_score = 7;
        reset = 1;
        @(posedge clk); #1;
        reset = 0; commit_valid = 0;
        model_reset();
        check("rst_commit_p1_total", p1_total, 0);
        check("rst_commit_ready", commit_ready, 1);
        no_pulse("rst_commit_no_pulse", 5);
        do_query(1, 2, 0, 0);

        commit(1, 4, 20, 1);
        reset = 1; new_game = 1;
        @(posedge clk); #1;
        reset = 0; new_game = 0;
        model_reset();
        check("both_p2_total", p2_total, 0);
        check("both_ready", commit_ready, 1);
        commit(1, 4, 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
